// File: rtl/eth_frame_rx_if.sv
// eth_frame_rx_if: groups the receive byte stream with the decoded header, payload and status outputs.
// Ports: rxd/rx_dv (byte stream in); dmac/smac/ether_type/hdr_valid; pld_data/pld_valid/pld_last;
//        frm_done/frm_ok/err_*; frm_cnt/err_cnt. master = stream source/observer, slave = receiver.
interface eth_frame_rx_if;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [15:0] ether_type;
  logic        hdr_valid;
  logic [7:0]  pld_data;
  logic        pld_valid;
  logic        pld_last;
  logic        frm_done;
  logic        frm_ok;
  logic        err_pre;
  logic        err_short;
  logic        err_long;
  logic        err_crc;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;

  modport master (
    output rxd, rx_dv,
    input  dmac, smac, ether_type, hdr_valid, pld_data, pld_valid, pld_last,
    input  frm_done, frm_ok, err_pre, err_short, err_long, err_crc, frm_cnt, err_cnt
  );

  modport slave (
    input  rxd, rx_dv,
    output dmac, smac, ether_type, hdr_valid, pld_data, pld_valid, pld_last,
    output frm_done, frm_ok, err_pre, err_short, err_long, err_crc, frm_cnt, err_cnt
  );
endinterface

// File: rtl/eth_frame_rx.sv
// eth_frame_rx: Ethernet frame receiver - preamble/SFD check, header capture, payload stream with FCS stripping,
// CRC-32 check, frame status and saturating good/bad frame counters. Latency: payload byte out 5 samples after it
// arrives, frm_done the cycle after rx_dv falls. No backpressure. Ports: clk, rst_n, bus (eth_frame_rx_if.slave).
module eth_frame_rx #(
  parameter int MIN_PLD = 46,
  parameter int MAX_PLD = 1500
) (
  input  logic          clk,
  input  logic          rst_n,
  eth_frame_rx_if.slave bus
);

  localparam logic [7:0]  PRE_B       = 8'h55;
  localparam logic [7:0]  SFD_B       = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_W       = 16'(MIN_PLD);
  localparam logic [15:0] MAX_W       = 16'(MAX_PLD);

  typedef enum logic [2:0] {IDLE, PRE, HDR, BODY, DROP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     pre_cnt_q;
  logic [3:0]     hdr_cnt_q;
  logic [103:0]   hdr_sh_q;
  logic [4:0][7:0] line_q;
  logic [2:0]     line_cnt_q;
  logic [15:0]    pld_cnt_q;
  logic [31:0]    crc_q;
  logic           pre_l_q;
  logic           long_l_q;

  logic line_full, at_max;
  logic hdr_take, hdr_fire, push, emit, emit_last, done;
  logic set_pre, set_long;
  logic f_pre, f_short, f_long, f_crc;

  assign line_full = (line_cnt_q == 3'd5);
  assign at_max    = (pld_cnt_q >= MAX_W);

  // Reflected CRC-32 step over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.rx_dv) state_d = (bus.rxd == PRE_B) ? PRE : DROP;
      PRE: begin
        if (!bus.rx_dv)                                    state_d = IDLE;
        else if (bus.rxd == PRE_B) begin
          if (pre_cnt_q == 4'd7)                           state_d = DROP; // eighth 0x55
        end
        else if (bus.rxd == SFD_B && pre_cnt_q == 4'd7)    state_d = HDR;
        else                                               state_d = DROP;
      end
      HDR: begin
        if (!bus.rx_dv)               state_d = IDLE;
        else if (hdr_cnt_q == 4'd13)  state_d = BODY;
      end
      BODY: begin
        if (!bus.rx_dv)               state_d = IDLE;
        else if (line_full && at_max) state_d = DROP;
      end
      DROP: if (!bus.rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-cycle actions decoded from state and inputs
  always_comb begin
    hdr_take  = 1'b0;
    hdr_fire  = 1'b0;
    push      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    done      = 1'b0;
    set_pre   = 1'b0;
    set_long  = 1'b0;
    f_pre     = 1'b0;
    f_short   = 1'b0;
    f_long    = 1'b0;
    f_crc     = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_dv && bus.rxd != PRE_B) set_pre = 1'b1;
      PRE: begin
        if (!bus.rx_dv) begin
          done    = 1'b1;
          f_short = 1'b1;
        end else if (bus.rxd == PRE_B) begin
          if (pre_cnt_q == 4'd7) set_pre = 1'b1;
        end else if (!(bus.rxd == SFD_B && pre_cnt_q == 4'd7)) begin
          set_pre = 1'b1;
        end
      end
      HDR: begin
        if (bus.rx_dv) begin
          hdr_take = 1'b1;
          hdr_fire = (hdr_cnt_q == 4'd13);
        end else begin
          done    = 1'b1;
          f_short = 1'b1;
        end
      end
      BODY: begin
        if (bus.rx_dv) begin
          if (line_full && at_max) begin
            set_long = 1'b1;
          end else begin
            push = 1'b1;
            emit = line_full;
          end
        end else if (line_full) begin
          done = 1'b1;
          if (at_max) begin
            // Emitting the final byte would exceed the payload limit.
            f_long = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_last = 1'b1;
            f_short   = (pld_cnt_q + 16'd1) < MIN_W;
            f_crc     = !f_short && (crc_q != CRC_RESIDUE);
          end
        end else begin
          done    = 1'b1;
          f_short = 1'b1;
        end
      end
      DROP: begin
        if (!bus.rx_dv) begin
          done   = 1'b1;
          f_pre  = pre_l_q;
          f_long = long_l_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      hdr_cnt_q      <= '0;
      hdr_sh_q       <= '0;
      line_q         <= '0;
      line_cnt_q     <= '0;
      pld_cnt_q      <= '0;
      crc_q          <= '0;
      pre_l_q        <= 1'b0;
      long_l_q       <= 1'b0;
      bus.dmac       <= '0;
      bus.smac       <= '0;
      bus.ether_type <= '0;
      bus.hdr_valid  <= 1'b0;
      bus.pld_data   <= '0;
      bus.pld_valid  <= 1'b0;
      bus.pld_last   <= 1'b0;
      bus.frm_done   <= 1'b0;
      bus.frm_ok     <= 1'b0;
      bus.err_pre    <= 1'b0;
      bus.err_short  <= 1'b0;
      bus.err_long   <= 1'b0;
      bus.err_crc    <= 1'b0;
      bus.frm_cnt    <= '0;
      bus.err_cnt    <= '0;
    end else begin
      if (state_q == IDLE)                  pre_cnt_q <= 4'd1;
      else if (state_q == PRE && bus.rx_dv) pre_cnt_q <= pre_cnt_q + 4'd1;

      // Every frame passes through PRE before HDR, so per-frame state is re-armed outside HDR/BODY.
      if (state_q != HDR && state_q != BODY) begin
        crc_q      <= '1;
        hdr_cnt_q  <= '0;
        line_cnt_q <= '0;
        pld_cnt_q  <= '0;
      end else begin
        if (hdr_take || push) crc_q <= crc_byte(crc_q, bus.rxd);
        if (hdr_take) begin
          hdr_cnt_q <= hdr_cnt_q + 4'd1;
          hdr_sh_q  <= {hdr_sh_q[95:0], bus.rxd};
        end
        if (push) begin
          line_q <= {line_q[3:0], bus.rxd};
          if (!line_full) line_cnt_q <= line_cnt_q + 3'd1;
        end
        if (emit) pld_cnt_q <= pld_cnt_q + 16'd1;
      end

      // Header outputs only change on the capture of byte 14.
      if (hdr_fire) begin
        bus.dmac       <= hdr_sh_q[103:56];
        bus.smac       <= hdr_sh_q[55:8];
        bus.ether_type <= {hdr_sh_q[7:0], bus.rxd};
      end
      bus.hdr_valid <= hdr_fire;

      bus.pld_valid <= emit;
      bus.pld_last  <= emit_last;
      if (emit) bus.pld_data <= line_q[4];

      if (done) begin
        pre_l_q  <= 1'b0;
        long_l_q <= 1'b0;
      end else begin
        if (set_pre)  pre_l_q  <= 1'b1;
        if (set_long) long_l_q <= 1'b1;
      end

      bus.frm_done  <= done;
      bus.frm_ok    <= done && !(f_pre || f_short || f_long || f_crc);
      bus.err_pre   <= f_pre;
      bus.err_short <= f_short;
      bus.err_long  <= f_long;
      bus.err_crc   <= f_crc;

      if (done) begin
        if (!(f_pre || f_short || f_long || f_crc)) begin
          if (bus.frm_cnt != 16'hFFFF) bus.frm_cnt <= bus.frm_cnt + 16'd1;
        end else begin
          if (bus.err_cnt != 16'hFFFF) bus.err_cnt <= bus.err_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Bench for eth_frame_rx (MAX_PLD=64): directed vector table, random frames against a frame-level model,
// latency, back-to-back and mid-frame reset sequences.
module tb_eth_frame_rx;
  localparam int MINP = 46;
  localparam int MAXP = 64;

  typedef struct {
    int n_pre; int sfd_n; logic [7:0] sfd; int hdr_n; int pld_n; int fcs_n; bit flip;
    bit e_pre; bit e_short; bit e_long; bit e_crc; int e_npld; bit e_last; bit e_hdr;
  } vec_t;

  typedef struct {
    bit e_pre; bit e_short; bit e_long; bit e_crc; int n_pld; bit last; bit hdr;
    logic [47:0] dmac; logic [47:0] smac; logic [15:0] et; int fcnt; int ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_frame_rx_if bus();
  eth_frame_rx #(.MIN_PLD(MINP), .MAX_PLD(MAXP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] frm_q[$];
  logic [7:0] pl_q[$];
  logic [7:0] exp_pld[$];
  exp_t       exp_q[$];
  int         edges[$];
  int         dv0_edge;
  int         exp_frm = 0;
  int         exp_err = 0;
  logic [111:0] hdr_c = 112'h001122334455_66778899AABB_0800;

  task automatic chk_i(input string name, input int got, input int expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic chk_v(input string name, input logic [255:0] got, input logic [255:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  // Standard Ethernet CRC-32 (with final inversion) of frm_q[from .. to-1].
  function automatic logic [31:0] crc32_of(input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) begin
      c = c ^ {24'h0, frm_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- monitor ----------------
  int cur_n, cur_cons, cur_mism, cur_last, cur_hdr, first_emit_edge, done_edge;
  logic [47:0] got_dmac, got_smac;
  logic [15:0] got_et;
  exp_t me;
  logic [7:0] eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_n = 0; cur_cons = 0; cur_mism = 0; cur_last = 0; cur_hdr = 0;
    end else begin
      if (bus.hdr_valid) begin
        cur_hdr++;
        got_dmac = bus.dmac; got_smac = bus.smac; got_et = bus.ether_type;
      end
      if (bus.pld_valid) begin
        if (cur_n == 0) first_emit_edge = cyc;
        if (exp_q.size() > 0 && cur_cons < exp_q[0].n_pld && exp_pld.size() > 0) begin
          eb = exp_pld.pop_front();
          cur_cons++;
          if (eb !== bus.pld_data) cur_mism++;
        end
        cur_n++;
        if (bus.pld_last) cur_last++;
      end
      if (bus.frm_done) begin
        done_edge = cyc;
        chk_i("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          me = exp_q.pop_front();
          while (cur_cons < me.n_pld && exp_pld.size() > 0) begin
            eb = exp_pld.pop_front();
            cur_cons++;
          end
          chk_v("flags", 256'({bus.err_pre, bus.err_short, bus.err_long, bus.err_crc}),
                256'({me.e_pre, me.e_short, me.e_long, me.e_crc}));
          chk_i("frm_ok", int'(bus.frm_ok), int'(!(me.e_pre || me.e_short || me.e_long || me.e_crc)));
          chk_i("pld_count", cur_n, me.n_pld);
          chk_i("pld_bytes_mismatched", cur_mism, 0);
          chk_i("pld_last_count", cur_last, int'(me.last));
          chk_i("pld_last_at_done", int'(bus.pld_last & bus.pld_valid), int'(me.last));
          chk_i("hdr_valid_count", cur_hdr, int'(me.hdr));
          if (me.hdr) chk_v("hdr_fields", 256'({got_dmac, got_smac, got_et}), 256'({me.dmac, me.smac, me.et}));
          chk_i("frm_cnt", int'(bus.frm_cnt), me.fcnt);
          chk_i("err_cnt", int'(bus.err_cnt), me.ecnt);
        end
        cur_n = 0; cur_cons = 0; cur_mism = 0; cur_last = 0; cur_hdr = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input exp_t e);
    if (!(e.e_pre || e.e_short || e.e_long || e.e_crc)) begin
      if (exp_frm < 16'hFFFF) exp_frm++;
    end else begin
      if (exp_err < 16'hFFFF) exp_err++;
    end
    e.fcnt = exp_frm;
    e.ecnt = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic build(input vec_t v);
    int st;
    logic [31:0] c;
    logic [7:0] f;
    frm_q.delete(); pl_q.delete();
    repeat (v.n_pre) frm_q.push_back(8'h55);
    if (v.sfd_n > 0) frm_q.push_back(v.sfd);
    st = frm_q.size();
    for (int k = 0; k < v.hdr_n; k++) frm_q.push_back(hdr_c[111 - 8*k -: 8]);
    for (int k = 0; k < v.pld_n; k++) begin
      frm_q.push_back(8'(k));
      pl_q.push_back(8'(k));
    end
    c = crc32_of(st, frm_q.size());
    for (int k = 0; k < v.fcs_n; k++) begin
      f = c[8*k +: 8];
      if (k == 0 && v.flip) f = f ^ 8'h01;
      frm_q.push_back(f);
    end
  endtask

  // Frame-level expectation straight from the receive rules.
  task automatic model_exp(output exp_t e);
    int n, i, np, h, b, p;
    logic [31:0] fcs;
    e = '{default: 0};
    n = frm_q.size(); i = 0; np = 0;
    while (i < n && np < 8 && frm_q[i] == 8'h55) begin np++; i++; end
    if (np == 0 || np == 8)                      e.e_pre = 1;
    else if (i == n)                             e.e_short = 1;
    else if (np != 7 || frm_q[i] != 8'hD5)       e.e_pre = 1;
    else begin
      h = i + 1;
      if (n - h < 14) e.e_short = 1;
      else begin
        e.hdr = 1;
        for (int k = 0; k < 6; k++) begin
          e.dmac[47 - 8*k -: 8] = frm_q[h + k];
          e.smac[47 - 8*k -: 8] = frm_q[h + 6 + k];
        end
        e.et = {frm_q[h + 12], frm_q[h + 13]};
        b = n - h - 14;
        if (b < 5) e.e_short = 1;
        else begin
          p = b - 4;
          if (p > MAXP) begin
            e.e_long = 1; e.n_pld = MAXP;
          end else begin
            e.n_pld = p; e.last = 1;
            if (p < MINP) e.e_short = 1;
            else begin
              fcs = {frm_q[n-1], frm_q[n-2], frm_q[n-3], frm_q[n-4]};
              e.e_crc = (crc32_of(h, n - 4) != fcs);
            end
          end
          for (int k = 0; k < e.n_pld; k++) exp_pld.push_back(frm_q[h + 14 + k]);
        end
      end
    end
  endtask

  // Drives frm_q[from..] then rx_dv=0 for `gap` cycles; call right after a posedge (+#1).
  task automatic send(input int from, input int gap);
    edges.delete();
    for (int i = from; i < frm_q.size(); i++) begin
      bus.rxd = frm_q[i]; bus.rx_dv = 1'b1;
      @(posedge clk); #1;
      edges.push_back(cyc);
    end
    bus.rxd = 8'h00; bus.rx_dv = 1'b0;
    @(posedge clk); #1;
    dv0_edge = cyc;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin @(posedge clk); #1; k++; end
    chk_i("frames_pending", exp_q.size(), 0);
  endtask

  function automatic logic [255:0] all_out();
    return 256'({bus.dmac, bus.smac, bus.ether_type, bus.hdr_valid, bus.pld_data, bus.pld_valid,
                 bus.pld_last, bus.frm_done, bus.frm_ok, bus.err_pre, bus.err_short, bus.err_long,
                 bus.err_crc, bus.frm_cnt, bus.err_cnt});
  endfunction

  // ---------------- test ----------------
  vec_t vecs[12];
  exp_t e;
  vec_t rv;
  int cut;

  initial begin
    vecs[0]  = '{7, 1, 8'hD5, 14,  46, 4, 0,  0, 0, 0, 0, 46, 1, 1}; // good
    vecs[1]  = '{7, 1, 8'hD5, 14,  46, 4, 1,  0, 0, 0, 1, 46, 1, 1}; // FCS bit flip
    vecs[2]  = '{6, 1, 8'hD5, 14,  46, 4, 0,  1, 0, 0, 0,  0, 0, 0}; // 6x 0x55
    vecs[3]  = '{7, 1, 8'hD5, 10,   0, 0, 0,  0, 1, 0, 0,  0, 0, 0}; // ends after 10 hdr bytes
    vecs[4]  = '{7, 1, 8'hD5, 14, 100, 4, 0,  0, 0, 1, 0, 64, 0, 1}; // over-long
    vecs[5]  = '{7, 1, 8'hD5, 14,  30, 4, 0,  0, 1, 0, 0, 30, 1, 1}; // short payload
    vecs[6]  = '{7, 1, 8'hD5, 14,  64, 4, 0,  0, 0, 0, 0, 64, 1, 1}; // exactly MAX
    vecs[7]  = '{7, 1, 8'hD5, 14,  65, 4, 0,  0, 0, 1, 0, 64, 0, 1}; // MAX+1
    vecs[8]  = '{8, 1, 8'hD5, 14,  46, 4, 0,  1, 0, 0, 0,  0, 0, 0}; // 8x 0x55
    vecs[9]  = '{7, 1, 8'hD5, 14,   3, 0, 0,  0, 1, 0, 0,  0, 0, 1}; // 3 body bytes
    vecs[10] = '{0, 1, 8'h00, 14,  46, 4, 0,  1, 0, 0, 0,  0, 0, 0}; // first byte not 0x55
    vecs[11] = '{3, 0, 8'hD5,  0,   0, 0, 0,  0, 1, 0, 0,  0, 0, 0}; // ends in preamble

    rst_n = 1'b0; bus.rxd = 8'h00; bus.rx_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_v("reset_state", all_out(), '0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed table
    for (int t = 0; t < 12; t++) begin
      build(vecs[t]);
      e = '{default: 0};
      e.e_pre = vecs[t].e_pre; e.e_short = vecs[t].e_short; e.e_long = vecs[t].e_long;
      e.e_crc = vecs[t].e_crc; e.n_pld = vecs[t].e_npld; e.last = vecs[t].e_last; e.hdr = vecs[t].e_hdr;
      e.dmac = 48'h001122334455; e.smac = 48'h66778899AABB; e.et = 16'h0800;
      for (int k = 0; k < vecs[t].e_npld; k++) exp_pld.push_back(pl_q[k]);
      push_exp(e);
      send(0, 3);
    end
    drain(200);

    // Latency on a good frame: payload byte 0 is the 23rd byte on the wire
    build(vecs[0]);
    model_exp(e);
    push_exp(e);
    send(0, 3);
    drain(50);
    chk_i("latency_pld", first_emit_edge - edges[22], 5);
    chk_i("latency_done", done_edge, dv0_edge);

    // Random frames against the model
    for (int r = 0; r < 40; r++) begin
      frm_q.delete();
      rv.n_pre = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 8)) : 7;
      repeat (rv.n_pre) frm_q.push_back(8'h55);
      frm_q.push_back(($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5);
      cut = frm_q.size();
      repeat (14 + $urandom_range(0, 75)) frm_q.push_back(8'($urandom_range(0, 255)));
      begin
        logic [31:0] c;
        c = crc32_of(cut, frm_q.size());
        if ($urandom_range(0, 3) == 0) c[$urandom_range(0, 31)] ^= 1'b1;
        for (int k = 0; k < 4; k++) frm_q.push_back(c[8*k +: 8]);
      end
      if ($urandom_range(0, 5) == 0) begin
        cut = $urandom_range(1, frm_q.size());
        while (frm_q.size() > cut) void'(frm_q.pop_back());
      end
      model_exp(e);
      push_exp(e);
      send(0, 1 + $urandom_range(0, 2));
    end
    drain(200);

    // Two good frames back to back, then reset in the payload of a third
    exp_frm = 0; exp_err = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 2; f++) begin
      build(vecs[0]);
      model_exp(e);
      push_exp(e);
      send(0, 1);
    end
    drain(50);
    chk_i("two_good_frm_cnt", int'(bus.frm_cnt), 2);
    build(vecs[0]);
    for (int i = 0; i < 30; i++) begin
      bus.rxd = frm_q[i]; bus.rx_dv = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_v("outputs_in_reset", all_out(), '0);
    for (int i = 30; i < 32; i++) begin
      bus.rxd = frm_q[i];
      @(posedge clk); #1;
    end
    chk_v("outputs_in_reset_held", all_out(), '0);
    rst_n = 1'b1;
    exp_frm = 0; exp_err = 0;
    for (int i = 0; i < 32; i++) void'(frm_q.pop_front());
    model_exp(e);
    push_exp(e);
    send(0, 3);
    drain(50);
    chk_i("third_err_cnt", int'(bus.err_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d expected=0", 1);
    $fatal(1, "timeout");
  end
endmodule
